// File: rtl/compare_arbiter_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
// Imported by the arbiter top and by the shared comparator.
package compare_arbiter_pkg;

    localparam int OPERAND_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESULT  = 2'd2
    } state_t;

endpackage

// File: rtl/compare_arbiter_comparator8bit.sv
// Shared unsigned 8-bit magnitude comparator.
// Exactly one of lt/gt/eq is high for any operand pair.
module Comparator8Bit
    import compare_arbiter_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic                     lt,
    output logic                     gt,
    output logic                     eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one Comparator8Bit between NUM_REQ requesters.
// Grant latches an operand pair; the result is registered and held until accepted.
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             res_valid,
    output logic [ID_WIDTH-1:0]              res_id,
    output logic                             res_lt,
    output logic                             res_gt,
    output logic                             res_eq,
    input  logic                             res_ready
);

    state_t                   state;
    state_t                   state_next;
    logic [ID_WIDTH-1:0]      rr_ptr;
    logic [OPERAND_WIDTH-1:0] op_a;
    logic [OPERAND_WIDTH-1:0] op_b;
    logic [ID_WIDTH-1:0]      op_id;
    logic                     grant_found;
    logic [ID_WIDTH-1:0]      grant_idx;
    logic [ID_WIDTH-1:0]      ptr_after_grant;
    logic                     cmp_lt;
    logic                     cmp_gt;
    logic                     cmp_eq;

    // Returns {found, index}: first valid requester at or after ptr, wrapping
    // modulo NUM_REQ. Scanning from the far end lets the nearest hit win last.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]  valid,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic [ID_WIDTH:0]   pick;
        logic [ID_WIDTH-1:0] idx;
        int                  sum;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            idx = ID_WIDTH'(sum % NUM_REQ);
            if (valid[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    assign {grant_found, grant_idx} = rr_pick(req_valid, rr_ptr);
    assign ptr_after_grant = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    Comparator8Bit u_comparator (
        .a  (op_a),
        .b  (op_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found && !reset) begin
                    req_ready  = NUM_REQ'(1) << grant_idx;
                    state_next = COMPARE;
                end
            end
            COMPARE: state_next = RESULT;
            RESULT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_lt    <= 1'b0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_a[grant_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
                        op_b   <= req_b[grant_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
                        op_id  <= grant_idx;
                        rr_ptr <= ptr_after_grant;
                    end
                end
                COMPARE: begin
                    res_valid <= 1'b1;
                    res_id    <= op_id;
                    res_lt    <= cmp_lt;
                    res_gt    <= cmp_gt;
                    res_eq    <= cmp_eq;
                end
                RESULT: begin
                    // Flags and id are left as-is; they only matter while res_valid is high.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
